// File: rtl/ripple_carry_adder_pkg.sv
// Datapath constants shared by the ripple-carry adder and its leaf cells.
package ripple_carry_adder_pkg;

  // Default operand/sum width of the adder.
  localparam int RCA_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the single stage of the ripple chain. Purely combinational.
module full_adder
  import ripple_carry_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the three-way parity; carry is the majority of the three inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder with carry-in/carry-out and a one-cycle
// registered result. The carry chain runs strictly LSB to MSB through WIDTH
// full_adder stages; there is no lookahead, so the critical path is the
// full chain from the operands into the Cout flop.
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // carry[i] feeds stage i; carry[WIDTH] is the carry-out of the MSB stage.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Capture the sum every cycle; reset wins over any operand value.
  always_ff @(posedge clk) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and back-to-back checks of the 8-bit registered ripple-carry adder.
module tb_ripple_carry_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] A, B;
  logic         C;
  logic [W-1:0] S;
  logic         Cout;

  int n_checks = 0;
  int n_fails  = 0;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .C    (C),
    .S    (S),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; A = 8'hFF; B = 8'h01; C = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (S !== 8'h00) begin
        n_fails++;
        $display("FAIL reset_s cyc%0d: got %h want 00", k, S);
      end
      n_checks++;
      if (Cout !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_cout cyc%0d: got %b want 0", k, Cout);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'h01 || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_release: got %b/%h want 1/01", Cout, S);
    end
  endtask

  task automatic test_basic();
    A = 8'h01; B = 8'h01; C = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'h02 || Cout !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_1p1: got %b/%h want 0/02", Cout, S);
    end
    A = 8'h0F; B = 8'h01; C = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'h10 || Cout !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_0fp1: got %b/%h want 0/10", Cout, S);
    end
    A = 8'h00; B = 8'h00; C = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'h00 || Cout !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_zero: got %b/%h want 0/00", Cout, S);
    end
    A = 8'h3C; B = 8'h21; C = 1'b1;
    tick();
    n_checks++;
    if (S !== 8'h5E || Cout !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_3cp21c: got %b/%h want 0/5e", Cout, S);
    end
  endtask

  task automatic test_wrap();
    A = 8'hFF; B = 8'h01; C = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'h00 || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL wrap_ffp1: got %b/%h want 1/00", Cout, S);
    end
    A = 8'hFF; B = 8'h00; C = 1'b1;
    tick();
    n_checks++;
    if (S !== 8'h00 || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL wrap_ffcin: got %b/%h want 1/00", Cout, S);
    end
  endtask

  task automatic test_full_carry();
    A = 8'hAA; B = 8'h55; C = 1'b1;
    tick();
    n_checks++;
    if (S !== 8'h00 || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL full_carry_aa55c: got %b/%h want 1/00", Cout, S);
    end
    A = 8'hAA; B = 8'h55; C = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'hFF || Cout !== 1'b0) begin
      n_fails++;
      $display("FAIL no_carry_aa55: got %b/%h want 0/ff", Cout, S);
    end
  endtask

  task automatic test_carry_overflow();
    A = 8'hF0; B = 8'hF0; C = 1'b1;
    tick();
    n_checks++;
    if (S !== 8'hE1 || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL ovf_f0f0c: got %b/%h want 1/e1", Cout, S);
    end
    A = 8'hFF; B = 8'hFF; C = 1'b1;
    tick();
    n_checks++;
    if (S !== 8'hFF || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL ovf_ffffc: got %b/%h want 1/ff", Cout, S);
    end
    A = 8'h80; B = 8'h80; C = 1'b0;
    tick();
    n_checks++;
    if (S !== 8'h00 || Cout !== 1'b1) begin
      n_fails++;
      $display("FAIL ovf_msb: got %b/%h want 1/00", Cout, S);
    end
  endtask

  // One new vector per cycle; rst pulsed at cycles 15-16 and 30.
  task automatic test_back_to_back();
    logic [W:0]   exp;
    logic [W-1:0] ra, rb;
    logic         rc;
    for (int k = 0; k < 40; k++) begin
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      rc  = 1'($urandom_range(0, 1));
      rst = (k == 15 || k == 16 || k == 30);
      A = ra; B = rb; C = rc;
      exp = rst ? '0 : ({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      tick();
      n_checks++;
      if ({Cout, S} !== exp) begin
        n_fails++;
        $display("FAIL b2b cyc%0d a=%h b=%h c=%b rst=%b: got %b/%h want %b/%h",
                 k, ra, rb, rc, rst, Cout, S, exp[W], exp[W-1:0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; A = '0; B = '0; C = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_wrap();
    test_full_carry();
    test_carry_overflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
